pipeline_stall_controller: RTL and testbench

- Consumer side of the hazard-detection path.
- Accepts the per-cycle bubble request and WB-forward flags from the load-use hazard unit, the branch-taken flush request from EX, and the data-memory busy signal.
- Sequences the actual pipeline control: PC/IF-ID write enables, ID/EX bubble insertion, IF-ID/ID-EX flush, EX-MEM/MEM-WB hold and the aligned WB-forward select pulses.
- Also maintains saturating performance counters.

---
 rtl/pipeline_stall_controller.sv | 113 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall/flush/bubble sequencer with saturating perf counters
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bubble_request,
    input  logic                 fwd_rs1_req,
    input  logic                 fwd_rs2_req,
    input  logic                 branch_taken,
    input  logic                 dmem_busy,
    output logic                 pc_write_en,
    output logic                 if_id_write_en,
    output logic                 id_ex_bubble,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_hold,
    output logic                 fwd_wb_rs1,
    output logic                 fwd_wb_rs2,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] bubble_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t     cur_state;
    state_t     next_state;
    logic [2:0] flush_cnt;
    logic       pend_rs1;
    logic       pend_rs2;

    always_comb begin
        next_state = cur_state;
        if (dmem_busy) begin
            next_state = MEM_WAIT;
        end else begin
            case (cur_state)
                RUN:      next_state = branch_taken ? FLUSH :
                                       (bubble_request ? BUBBLE : RUN);
                BUBBLE:   next_state = branch_taken ? FLUSH : RUN;
                FLUSH:    next_state = (flush_cnt == 3'd0) ? RUN : FLUSH;
                MEM_WAIT: next_state = RUN;
                default:  next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= RUN;
            flush_cnt    <= 3'd0;
            pend_rs1     <= 1'b0;
            pend_rs2     <= 1'b0;
            fwd_wb_rs1   <= 1'b0;
            fwd_wb_rs2   <= 1'b0;
            bubble_count <= '0;
            flush_count  <= '0;
            stall_count  <= '0;
        end else begin
            cur_state  <= next_state;
            fwd_wb_rs1 <= 1'b0;
            fwd_wb_rs2 <= 1'b0;

            if (next_state == FLUSH && cur_state != FLUSH) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (cur_state == FLUSH && flush_cnt != 3'd0) begin
                flush_cnt <= flush_cnt - 3'd1;
            end

            // Forward flags survive a MEM_WAIT detour and fire on the first RUN cycle after it.
            if (cur_state == RUN && next_state == BUBBLE) begin
                pend_rs1 <= fwd_rs1_req;
                pend_rs2 <= fwd_rs2_req;
            end else if (cur_state == BUBBLE && next_state == FLUSH) begin
                pend_rs1 <= 1'b0;
                pend_rs2 <= 1'b0;
            end else if (next_state == RUN &&
                         (cur_state == BUBBLE || cur_state == MEM_WAIT)) begin
                fwd_wb_rs1 <= pend_rs1;
                fwd_wb_rs2 <= pend_rs2;
                pend_rs1   <= 1'b0;
                pend_rs2   <= 1'b0;
            end

            if (cur_state == RUN && next_state == BUBBLE && bubble_count != CNT_MAX)
                bubble_count <= bubble_count + 1'b1;
            if (cur_state != FLUSH && next_state == FLUSH && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
            if (cur_state == MEM_WAIT && stall_count != CNT_MAX)
                stall_count <= stall_count + 1'b1;
        end
    end

    assign state          = cur_state;
    assign pc_write_en    = (cur_state == RUN) || (cur_state == FLUSH);
    assign if_id_write_en = (cur_state == RUN) || (cur_state == FLUSH);
    assign id_ex_bubble   = (cur_state == BUBBLE);
    assign if_id_flush    = (cur_state == FLUSH);
    assign id_ex_flush    = (cur_state == FLUSH);
    assign mem_hold       = (cur_state == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bubble_request = 1'b0, fwd_rs1_req = 1'b0, fwd_rs2_req = 1'b0;
    logic branch_taken = 1'b0, dmem_busy = 1'b0;
    logic pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, id_ex_flush, mem_hold;
    logic fwd_wb_rs1, fwd_wb_rs2;
    logic [1:0]    state;
    logic [CW-1:0] bubble_count, flush_count, stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .bubble_request(bubble_request), .fwd_rs1_req(fwd_rs1_req), .fwd_rs2_req(fwd_rs2_req),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_hold(mem_hold),
        .fwd_wb_rs1(fwd_wb_rs1), .fwd_wb_rs2(fwd_wb_rs2), .state(state),
        .bubble_count(bubble_count), .flush_count(flush_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase-level view (0 RUN, 1 BUBBLE, 2 FLUSH, 3 MEM_WAIT)
    int m_phase, m_flush_left, m_pend1, m_pend2, m_pulse1, m_pulse2;
    int m_bub, m_fl, m_st;

    task automatic model_reset();
        m_phase = 0; m_flush_left = 0; m_pend1 = 0; m_pend2 = 0;
        m_pulse1 = 0; m_pulse2 = 0; m_bub = 0; m_fl = 0; m_st = 0;
    endtask

    task automatic model_step(input int b, input int f1, input int f2, input int br, input int busy);
        int prev, nxt;
        prev = m_phase;
        if (busy != 0)                 nxt = 3;
        else if (prev == 0)            nxt = (br != 0) ? 2 : ((b != 0) ? 1 : 0);
        else if (prev == 1)            nxt = (br != 0) ? 2 : 0;
        else if (prev == 2)            nxt = (m_flush_left <= 1) ? 0 : 2;
        else                           nxt = 0;
        m_pulse1 = 0; m_pulse2 = 0;
        if (prev == 3 && m_st < MAX) m_st++;
        if (prev == 0 && nxt == 1) begin
            if (m_bub < MAX) m_bub++;
            m_pend1 = f1; m_pend2 = f2;
        end
        if (prev != 2 && nxt == 2) begin
            if (m_fl < MAX) m_fl++;
            m_flush_left = FC;
            if (prev == 1) begin m_pend1 = 0; m_pend2 = 0; end
        end else if (prev == 2 && nxt == 2) begin
            m_flush_left--;
        end
        if (nxt == 0 && (prev == 1 || prev == 3)) begin
            m_pulse1 = m_pend1; m_pulse2 = m_pend2;
            m_pend1 = 0; m_pend2 = 0;
        end
        m_phase = nxt;
    endtask

    function automatic logic [9:0] model_ctrl();
        logic run_or_flush;
        run_or_flush = (m_phase == 0) || (m_phase == 2);
        return {run_or_flush, run_or_flush, m_phase == 1, m_phase == 2, m_phase == 2,
                m_phase == 3, m_pulse1 != 0, m_pulse2 != 0, 2'(m_phase)};
    endfunction

    logic [9:0] act_ctrl;
    assign act_ctrl = {pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, id_ex_flush,
                       mem_hold, fwd_wb_rs1, fwd_wb_rs2, state};

    // Called at a negedge: apply inputs, take one posedge, return at next negedge.
    task automatic tick(input logic b, input logic f1, input logic f2, input logic br, input logic busy);
        bubble_request = b; fwd_rs1_req = f1; fwd_rs2_req = f2; branch_taken = br; dmem_busy = busy;
        @(posedge clk);
        model_step(b, f1, f2, br, busy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bubble_request = 0; fwd_rs1_req = 0; fwd_rs2_req = 0; branch_taken = 0; dmem_busy = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick(0, 0, 0, 0, 0);
        checks++;
        if (act_ctrl !== 10'b1100000000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", act_ctrl, 10'b1100000000);
        end
        checks++;
        if ({bubble_count, flush_count, stall_count} !== '0) begin
            errors++; $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0",
                               bubble_count, flush_count, stall_count);
        end
    endtask

    task automatic test_bubble_forward();
        do_reset();
        tick(1, 1, 0, 0, 0);
        checks++;
        if (state !== 2'd1 || id_ex_bubble !== 1'b1 || pc_write_en !== 1'b0 || if_id_write_en !== 1'b0) begin
            errors++; $display("FAIL bubble_enter: state=%0d bub=%b pc=%b ifid=%b expected 1/1/0/0",
                               state, id_ex_bubble, pc_write_en, if_id_write_en);
        end
        tick(1, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd0 || fwd_wb_rs1 !== 1'b1 || fwd_wb_rs2 !== 1'b0 || bubble_count !== 4'd1) begin
            errors++; $display("FAIL bubble_fwd_pulse: state=%0d rs1=%b rs2=%b cnt=%0d expected 0/1/0/1",
                               state, fwd_wb_rs1, fwd_wb_rs2, bubble_count);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (fwd_wb_rs1 !== 1'b0 || fwd_wb_rs2 !== 1'b0) begin
            errors++; $display("FAIL bubble_fwd_clear: rs1=%b rs2=%b expected 0/0", fwd_wb_rs1, fwd_wb_rs2);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        tick(1, 1, 1, 1, 0);
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (state !== 2'd2 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || pc_write_en !== 1'b1) begin
                errors++; $display("FAIL flush_cycle%0d: state=%0d iff=%b idf=%b pc=%b expected 2/1/1/1",
                                   i, state, if_id_flush, id_ex_flush, pc_write_en);
            end
            tick(0, 0, 0, 0, 0);
        end
        checks++;
        if (state !== 2'd0 || flush_count !== 4'd1 || bubble_count !== 4'd0 ||
            fwd_wb_rs1 !== 1'b0 || fwd_wb_rs2 !== 1'b0) begin
            errors++; $display("FAIL flush_exit: state=%0d fl=%0d bub=%0d rs1=%b rs2=%b expected 0/1/0/0/0",
                               state, flush_count, bubble_count, fwd_wb_rs1, fwd_wb_rs2);
        end
    endtask

    task automatic test_bubble_mem_wait();
        do_reset();
        tick(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 1);
            checks++;
            if (state !== 2'd3 || mem_hold !== 1'b1 || pc_write_en !== 1'b0 || fwd_wb_rs2 !== 1'b0) begin
                errors++; $display("FAIL mem_wait%0d: state=%0d hold=%b pc=%b rs2=%b expected 3/1/0/0",
                                   i, state, mem_hold, pc_write_en, fwd_wb_rs2);
            end
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (state !== 2'd0 || fwd_wb_rs2 !== 1'b1 || fwd_wb_rs1 !== 1'b0 || stall_count !== 4'd3) begin
            errors++; $display("FAIL mem_wait_exit: state=%0d rs2=%b rs1=%b stall=%0d expected 0/1/0/3",
                               state, fwd_wb_rs2, fwd_wb_rs1, stall_count);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (fwd_wb_rs2 !== 1'b0) begin
            errors++; $display("FAIL mem_wait_pulse_once: rs2=%b expected 0", fwd_wb_rs2);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0);
        end
        checks++;
        if (bubble_count !== 4'd15) begin
            errors++; $display("FAIL bubble_saturate: got %0d expected 15", bubble_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (act_ctrl !== 10'b1100000000 || stall_count !== 4'd0) begin
            errors++; $display("FAIL async_reset: ctrl=%b stall=%0d expected 1100000000/0", act_ctrl, stall_count);
        end
        reset = 1'b0;
        dmem_busy = 1'b0;
        tick(0, 0, 0, 0, 0);
        checks++;
        if (state !== 2'd0 || stall_count !== 4'd0) begin
            errors++; $display("FAIL async_reset_after: state=%0d stall=%0d expected 0/0", state, stall_count);
        end
    endtask

    task automatic test_random();
        logic b, f1, f2, br, busy;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            b    = ($urandom_range(0, 2) == 0);
            f1   = $urandom_range(0, 1);
            f2   = $urandom_range(0, 1);
            br   = ($urandom_range(0, 5) == 0);
            busy = ($urandom_range(0, 6) == 0);
            tick(b, f1, f2, br, busy);
            checks++;
            if (act_ctrl !== model_ctrl()) begin
                errors++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", i, act_ctrl, model_ctrl());
            end
            checks++;
            if (bubble_count !== CW'(m_bub) || flush_count !== CW'(m_fl) || stall_count !== CW'(m_st)) begin
                errors++; $display("FAIL random_counters cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   i, bubble_count, flush_count, stall_count, m_bub, m_fl, m_st);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bubble_forward();
        test_branch_priority();
        test_bubble_mem_wait();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
